imm_gen_fifo: RTL and testbench

Parametrised, buffered immediate generator for the RISC-V decode path. It accepts the upper 25 instruction bits plus a format code and decodes all base immediate formats (I, S, B, U, J). Each decoded immediate, sign-extended to WORD_LENGTH, is pushed into a small FIFO with valid/ready handshakes on both sides, so decode and execute can stall independently. It supersedes the I/S-only combinational sign extender.

---
 rtl/imm_gen_fifo_if.sv | 49 ++++
 rtl/imm_gen_fifo.sv | 116 +++++++++++
 tb/tb_imm_gen_fifo.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_fifo_if.sv
// =====================================================================
// imm_gen_fifo_if : valid/ready bus for the buffered immediate generator
// Macro IMM_ILLEGAL_EN adds err_out.            Rev 1.0
// =====================================================================
`default_nettype none

interface imm_gen_fifo_if #(
    parameter int WORD_LENGTH = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [24:0]            instr_part;
    logic [2:0]             cntrl;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_LENGTH-1:0] data_out;
`ifdef IMM_ILLEGAL_EN
    logic                   err_out;
`endif

    // Producer/consumer side (decode stage and execute stage)
    modport master (
        output in_valid,
        output instr_part,
        output cntrl,
        output out_ready,
        input  in_ready,
        input  out_valid,
`ifdef IMM_ILLEGAL_EN
        input  err_out,
`endif
        input  data_out
    );

    modport slave (
        input  in_valid,
        input  instr_part,
        input  cntrl,
        input  out_ready,
        output in_ready,
        output out_valid,
`ifdef IMM_ILLEGAL_EN
        output err_out,
`endif
        output data_out
    );
endinterface

`default_nettype wire

// File: rtl/imm_gen_fifo.sv
// =====================================================================
// imm_gen_fifo : RISC-V I/S/B/U/J immediate decoder feeding a FIFO.
// Macro IMM_ILLEGAL_EN stores an err bit per entry.   Rev 1.0
// =====================================================================
`default_nettype none

module imm_gen_fifo #(
    parameter int WORD_LENGTH = 32,
    parameter int FIFO_DEPTH  = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    imm_gen_fifo_if.slave      bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] C_I_LOAD = 3'b100;
    localparam logic [2:0] C_I_ALU  = 3'b010;
    localparam logic [2:0] C_S      = 3'b001;
    localparam logic [2:0] C_B      = 3'b011;
    localparam logic [2:0] C_U      = 3'b101;
    localparam logic [2:0] C_J      = 3'b110;

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q,  count_d;
    logic [WORD_LENGTH-1:0] mem_q [FIFO_DEPTH];

    logic [24:0]            ip;
    logic [31:0]            imm32;
    logic [WORD_LENGTH-1:0] imm_d;
    logic                   full, empty, push, pop;

    assign ip    = bus.instr_part;
    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid && !full;
    assign pop   = bus.out_ready && !empty;

    // Every format's sign bit is instr[31] (ip[24]), so decode to 32 bits first.
    always_comb begin
        imm32 = 32'h0;
        case (bus.cntrl)
            C_I_LOAD, C_I_ALU: imm32 = {{20{ip[24]}}, ip[24:13]};
            C_S:               imm32 = {{20{ip[24]}}, ip[24:18], ip[4:0]};
            C_B:               imm32 = {{19{ip[24]}}, ip[24], ip[0], ip[23:18], ip[4:1], 1'b0};
            C_U:               imm32 = {ip[24:5], 12'h000};
            C_J:               imm32 = {{11{ip[24]}}, ip[24], ip[12:5], ip[13], ip[23:14], 1'b0};
            default:           imm32 = 32'h0;
        endcase
    end

    always_comb begin
        imm_d        = {WORD_LENGTH{imm32[31]}};
        imm_d[31:0]  = imm32;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the empty gate below masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= imm_d;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.out_valid = !empty;
    assign bus.data_out  = empty ? '0 : mem_q[rd_ptr_q];

`ifdef IMM_ILLEGAL_EN
    logic err_mem_q [FIFO_DEPTH];
    logic err_d;

    assign err_d = (bus.cntrl == 3'b000) || (bus.cntrl == 3'b111);

    always_ff @(posedge clk) begin
        if (push) begin
            err_mem_q[wr_ptr_q] <= err_d;
        end
    end

    assign bus.err_out = empty ? 1'b0 : err_mem_q[rd_ptr_q];
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_fifo.sv
// =====================================================================
// tb_imm_gen_fifo : randomized bench for imm_gen_fifo against a queue model.
// Rev 1.0
// =====================================================================
`default_nettype none

module tb_imm_gen_fifo;
    localparam int WL    = 64;
    localparam int DEPTH = 2;

    typedef struct {
        logic [WL-1:0] v;
        logic          e;
    } ent_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    ent_t mdl_q [$];

    imm_gen_fifo_if #(.WORD_LENGTH(WL)) bus ();

    imm_gen_fifo #(
        .WORD_LENGTH (WL),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WL-1:0] obs, input logic [WL-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference decode from the architectural instruction layout.
    function automatic logic [WL-1:0] ref_imm(input logic [24:0] ip, input logic [2:0] c);
        logic [31:0]        ins;
        logic signed [63:0] v;
        ins = {ip, 7'h13};
        case (c)
            3'b100, 3'b010: v = 64'($signed(ins[31:20]));
            3'b001:         v = 64'($signed({ins[31:25], ins[11:7]}));
            3'b011:         v = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            3'b101:         v = 64'($signed({ins[31:12], 12'h000}));
            3'b110:         v = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            default:        v = 64'sd0;
        endcase
        return v[WL-1:0];
    endfunction

    task automatic check_outputs();
        logic [WL-1:0] exp_d;
        exp_d = (mdl_q.size() != 0) ? mdl_q[0].v : '0;
        chk("out_valid", WL'(bus.out_valid), WL'(mdl_q.size() != 0));
        chk("in_ready",  WL'(bus.in_ready),  WL'(mdl_q.size() < DEPTH));
        chk("data_out",  bus.data_out, exp_d);
`ifdef IMM_ILLEGAL_EN
        chk("err_out", WL'(bus.err_out), WL'((mdl_q.size() != 0) ? mdl_q[0].e : 1'b0));
`endif
    endtask

    // One clock: check state at negedge, optionally the head against a constant, drive, update model.
    task automatic cyc(input logic iv, input logic [31:0] instr, input logic [2:0] c,
                       input logic ordy, input logic head_en, input logic [WL-1:0] head_exp);
        bit   do_push, do_pop;
        ent_t ent;
        @(negedge clk);
        check_outputs();
        if (head_en) begin
            chk("head_const", bus.data_out, head_exp);
        end
        bus.in_valid   = iv;
        bus.instr_part = instr[31:7];
        bus.cntrl      = c;
        bus.out_ready  = ordy;
        do_push = iv && (mdl_q.size() < DEPTH);
        do_pop  = ordy && (mdl_q.size() != 0);
        if (do_pop) begin
            void'(mdl_q.pop_front());
        end
        if (do_push) begin
            ent.v = ref_imm(instr[31:7], c);
            ent.e = (c == 3'b000) || (c == 3'b111);
            mdl_q.push_back(ent);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.instr_part = '0;
        bus.cntrl      = 3'b000;
        bus.out_ready  = 1'b0;

        #2;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // I-alu all-ones, then S / B / J streamed with out_ready high
        cyc(1'b1, 32'hFFF00093, 3'b010, 1'b1, 1'b0, '0);
        cyc(1'b1, 32'hFE20AE23, 3'b001, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc(1'b1, 32'h00000863, 3'b011, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b1, 32'hFFDFF06F, 3'b110, 1'b1, 1'b1, 64'h0000_0000_0000_0010);
        cyc(1'b0, 32'h0,        3'b000, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1'b0, 32'h0,        3'b000, 1'b1, 1'b0, '0);

        // U-type sign extension to 64 bits
        cyc(1'b1, 32'h80000037, 3'b101, 1'b1, 1'b0, '0);
        cyc(1'b1, 32'h123450B7, 3'b101, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000);
        cyc(1'b0, 32'h0,        3'b000, 1'b1, 1'b1, 64'h0000_0000_1234_5000);

        // Fill with consumer stalled; third push must be dropped
        cyc(1'b1, 32'h00100093, 3'b010, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h00200093, 3'b100, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h00300093, 3'b010, 1'b0, 1'b0, '0);
        cyc(1'b0, 32'h0,        3'b000, 1'b1, 1'b1, 64'h1);
        cyc(1'b0, 32'h0,        3'b000, 1'b1, 1'b1, 64'h2);
        cyc(1'b0, 32'h0,        3'b000, 1'b1, 1'b0, '0);

        // Seven pushes with out_ready toggling: wraps and simultaneous push/pop
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, {12'(i + 1), 13'h0, 7'h13}, 3'b010, 1'(i % 2), 1'b0, '0);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, '0);
        end

        // Asynchronous reset with two entries buffered
        cyc(1'b1, 32'hABC00093, 3'b010, 1'b0, 1'b0, '0);
        cyc(1'b1, 32'h12300093, 3'b010, 1'b0, 1'b0, '0);
        cyc(1'b0, 32'h0,        3'b000, 1'b0, 1'b0, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", WL'(bus.out_valid), '0);
        chk("rst_data_out",  bus.data_out, '0);
        chk("rst_in_ready",  WL'(bus.in_ready), WL'(1'b1));
        mdl_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Illegal format code pushes zero (and flags err when enabled)
        cyc(1'b1, 32'hFFFFFFFF, 3'b111, 1'b1, 1'b0, '0);
        cyc(1'b1, 32'hFFFFFFFF, 3'b000, 1'b1, 1'b1, '0);
`ifdef IMM_ILLEGAL_EN
        chk("err_illegal", WL'(bus.err_out), WL'(1'b1));
`endif
        cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, '0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 2) != 0), 1'b0, '0);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            cyc(1'b0, 32'h0, 3'b000, 1'b1, 1'b0, '0);
        end
        @(negedge clk);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
